// File: rtl/muldiv_ctrl.sv
// Sequencer for an iterative multiply/divide unit: issues the load strobe,
// times the iteration phase, and commits the unit result into HI/LO.
module muldiv_ctrl #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op_div,
  input  logic [31:0] srcB,
  input  logic        flush,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  output logic        multCtrl,
  output logic        divCtrl,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CW = $clog2(ITER) + 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic   [CW-1:0] cnt;
  logic            op_q;
  logic            zero_req;
  logic            accept;

  // A divide with a zero divisor never occupies the unit; it only raises div_zero.
  assign zero_req = (state == IDLE) && start && !flush && op_div && (srcB == 32'd0);
  assign accept   = (state == IDLE) && start && !flush && !zero_req;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      op_q     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state    <= state_nxt;
      div_zero <= zero_req;
      if (accept) op_q <= op_div;
      if (state == LOAD)     cnt <= '0;
      else if (state == RUN) cnt <= cnt + 1'b1;
    end
  end

  // HI/LO only change on an unflushed DONE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (state == DONE && !flush) begin
      hi <= op_q ? div_hi : mult_hi;
      lo <= op_q ? div_lo : mult_lo;
    end
  end

  // NOTE: every combinational output gets a default first so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = LOAD;
      LOAD: state_nxt = flush ? IDLE : RUN;
      RUN: begin
        if (flush)                         state_nxt = IDLE;
        else if (cnt == CW'(ITER - 1))     state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    multCtrl = 1'b0;
    divCtrl  = 1'b0;
    busy     = (state != IDLE);
    done     = (state == DONE);
    if (state == LOAD) begin
      multCtrl = !op_q;
      divCtrl  = op_q;
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: a vector table run against a small
// multiply/divide unit model, plus hand-built flush, overlap and reset sequences.
module tb_muldiv_ctrl;

  localparam int ITER = 32;

  logic        clk = 1'b0;
  logic        reset, start, op_div, flush;
  logic [31:0] srcB, mult_hi, mult_lo, div_hi, div_lo;
  logic        multCtrl, divCtrl, busy, done, div_zero;
  logic [31:0] hi, lo;

  logic [31:0] op_a, op_b;
  longint      prod;

  always #5 clk = ~clk;

  muldiv_ctrl #(.ITER(ITER)) dut (
    .clk(clk), .reset(reset), .start(start), .op_div(op_div), .srcB(srcB),
    .flush(flush), .mult_hi(mult_hi), .mult_lo(mult_lo), .div_hi(div_hi),
    .div_lo(div_lo), .multCtrl(multCtrl), .divCtrl(divCtrl), .busy(busy),
    .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  // Unit model: signed multiplier, unsigned divider, both following the operands.
  assign srcB = op_b;
  always_comb begin
    prod    = longint'($signed(op_a)) * longint'($signed(op_b));
    mult_hi = prod[63:32];
    mult_lo = prod[31:0];
    div_hi  = 32'd0;
    div_lo  = 32'd0;
    if (op_b != 32'd0) begin
      div_hi = op_a % op_b;
      div_lo = op_a / op_b;
    end
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_hilo = 64'd0;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        zero;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Drives a one-cycle start; returns at the first negedge after the start edge.
  task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b);
    op_div = op;
    op_a   = a;
    op_b   = b;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  // Called in the LOAD cycle; follows the operation to the cycle after DONE.
  task automatic finish_op(input logic op);
    int k;
    int busy_cycles;
    logic [63:0] e;
    check("load_multCtrl", multCtrl, !op);
    check("load_divCtrl", divCtrl, op);
    k = 1;
    busy_cycles = busy ? 1 : 0;
    while (!done && k < ITER + 6) begin
      tick();
      k++;
      if (busy) busy_cycles++;
    end
    check("done_cycle", k, ITER + 2);
    check("busy_cycles", busy_cycles, ITER + 2);
    tick();
    check("done_one_cycle", done, 1'b0);
    check("busy_after_done", busy, 1'b0);
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard: got result %0h expected none", {hi, lo});
    end else begin
      e = exp_q.pop_front();
      n_checks--;
      check("hilo_result", {hi, lo}, e);
      last_hilo = e;
    end
  endtask

  task automatic skip_to(input int from_k, input int to_k);
    for (int i = from_k; i < to_k; i++) tick();
  endtask

  initial begin
    int dones;

    vecs[0] = '{1'b0, 32'd3,          32'hFFFF_FFFE, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[1] = '{1'b1, 32'd37,         32'd7,         1'b0, 32'd2,         32'd5};
    vecs[2] = '{1'b1, 32'd9,          32'd0,         1'b1, 32'd0,         32'd0};
    vecs[3] = '{1'b0, 32'h0001_0000,  32'h0001_0000, 1'b0, 32'd1,         32'd0};
    vecs[4] = '{1'b1, 32'hFFFF_FFFF,  32'd16,        1'b0, 32'h0000_000F, 32'h0FFF_FFFF};
    vecs[5] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b0, 32'd0,         32'd1};

    reset = 1'b1; start = 1'b0; op_div = 1'b0; flush = 1'b0;
    op_a = 32'd0; op_b = 32'd0;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_strobes", {multCtrl, divCtrl}, 2'b00);
    check("rst_div_zero", div_zero, 1'b0);
    check("rst_hilo", {hi, lo}, 64'd0);

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].zero) begin
        issue(vecs[i].op, vecs[i].a, vecs[i].b);
        check("dz_pulse", div_zero, 1'b1);
        check("dz_busy", busy, 1'b0);
        check("dz_strobes", {multCtrl, divCtrl}, 2'b00);
        check("dz_hilo", {hi, lo}, last_hilo);
        tick();
        check("dz_one_cycle", div_zero, 1'b0);
      end else begin
        exp_q.push_back({vecs[i].ehi, vecs[i].elo});
        issue(vecs[i].op, vecs[i].a, vecs[i].b);
        finish_op(vecs[i].op);
      end
    end

    // Flush alongside start in IDLE suppresses both the operation and div_zero.
    flush = 1'b1;
    issue(1'b1, 32'd4, 32'd0);
    flush = 1'b0;
    check("idle_flush_dz", div_zero, 1'b0);
    check("idle_flush_busy", busy, 1'b0);
    flush = 1'b1;
    issue(1'b0, 32'd4, 32'd4);
    flush = 1'b0;
    check("idle_flush_start", busy, 1'b0);

    // Flush in LOAD.
    issue(1'b1, 32'd50, 32'd3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("load_flush_busy", busy, 1'b0);
    check("load_flush_strobe", divCtrl, 1'b0);

    // Flush at RUN cnt=10 (cycle 12 after start), then a normal operation.
    issue(1'b0, 32'd5, 32'd5);
    skip_to(1, 12);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("run_flush_busy", busy, 1'b0);
    check("run_flush_done", done, 1'b0);
    check("run_flush_hilo", {hi, lo}, last_hilo);
    dones = 0;
    for (int i = 0; i < ITER + 4; i++) begin
      tick();
      if (done) dones++;
    end
    check("run_flush_no_done", dones, 0);
    exp_q.push_back({32'd0, 32'd42});
    issue(1'b0, 32'd6, 32'd7);
    finish_op(1'b0);

    // Flush in DONE leaves HI/LO untouched.
    issue(1'b1, 32'd100, 32'd9);
    skip_to(1, ITER + 2);
    check("done_reached", done, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("done_flush_hilo", {hi, lo}, last_hilo);
    check("done_flush_busy", busy, 1'b0);

    // Starts during RUN and during DONE are ignored; exactly one done pulse.
    exp_q.push_back({32'd3, 32'd14});
    issue(1'b1, 32'd101, 32'd7);
    dones = 0;
    skip_to(1, 10);
    op_a = 32'd101; start = 1'b1;
    tick();
    start = 1'b0;
    skip_to(11, ITER + 2);
    check("ovl_done_cycle", done, 1'b1);
    if (done) dones++;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ovl_busy_after", busy, 1'b0);
    check("ovl_hilo", {hi, lo}, exp_q.size() > 0 ? exp_q[0] : 64'hX);
    if (exp_q.size() > 0) last_hilo = exp_q.pop_front();
    for (int i = 0; i < ITER + 4; i++) begin
      if (done || busy) dones++;
      tick();
    end
    check("ovl_one_done", dones, 1);

    // Reset at RUN cnt=5 (cycle 7 after start).
    issue(1'b0, 32'd11, 32'd13);
    skip_to(1, 7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_strobes", {multCtrl, divCtrl}, 2'b00);
    check("mid_rst_busy_done", {busy, done}, 2'b00);
    check("mid_rst_div_zero", div_zero, 1'b0);
    check("mid_rst_hilo", {hi, lo}, 64'd0);
    for (int i = 0; i < ITER + 4; i++) tick();
    check("mid_rst_discard", {hi, lo}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter ITER, default 32, meaning the number of iteration cycles the multiply/divide datapath needs after its load cycle.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, a one-cycle request to begin an operation.
REQ-005 SHALL have port op_div, input, 1, operation select sampled with start: 0 = mult, 1 = div.
REQ-006 SHALL have port srcB, input, 32, the divisor/multiplier operand, sampled with start for the zero check.
REQ-007 SHALL have port flush, input, 1, a synchronous abort of any operation in progress.
REQ-008 SHALL have ports mult_hi and mult_lo, input, 32 each, the result outputs of the multiplier unit.
REQ-009 SHALL have ports div_hi and div_lo, input, 32 each, the remainder and quotient outputs of the divider unit.
REQ-010 SHALL have ports multCtrl and divCtrl, output, 1 each, the load strobes to the respective units.
REQ-011 SHALL have port busy, output, 1, a stall request to the CPU control unit.
REQ-012 SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-013 SHALL have port div_zero, output, 1, a one-cycle divide-by-zero exception pulse.
REQ-014 SHALL have ports hi and lo, output, 32 each, the architectural HI/LO registers.

Function
REQ-015 SHALL implement the states IDLE, LOAD, RUN and DONE, encoded in a registered state vector.
REQ-016 In IDLE, start=1 with op_div=1 and srcB==0 SHALL go to IDLE, with div_zero=1 in the next cycle and no HI/LO change.
REQ-017 In IDLE, any other start=1 SHALL latch op_div into op_q and go to LOAD.
REQ-018 LOAD SHALL last exactly one cycle, with multCtrl=1 when op_q=0 or divCtrl=1 when op_q=1; the other strobe SHALL stay 0.
REQ-019 LOAD SHALL go to RUN and clear the iteration counter cnt to 0.
REQ-020 In RUN, both strobes SHALL be 0 and cnt SHALL increment each cycle.
REQ-021 RUN SHALL go to DONE on the cycle in which cnt==ITER-1, so RUN lasts exactly ITER cycles.
REQ-022 In DONE, for one cycle: hi/lo SHALL capture mult_hi/mult_lo (op_q=0) or div_hi/div_lo (op_q=1) at the closing edge, done=1, and the next state SHALL be IDLE.
REQ-023 busy SHALL be 1 in LOAD, RUN and DONE and 0 in IDLE, all states decoded combinationally.
REQ-024 Latency SHALL be ITER+3 cycles from start to visible hi/lo:
- the start edge enters LOAD;
- there are ITER RUN cycles;
- the new hi/lo are visible in the cycle after DONE.
REQ-025 start while busy=1 SHALL be ignored, with no queuing.
REQ-026 A start in the same cycle DONE is active SHALL be ignored; the requester re-issues it after busy falls.
REQ-027 flush=1 in LOAD, RUN or DONE SHALL go to IDLE at the next edge, with no HI/LO write and no done pulse.
REQ-028 flush=1 in IDLE SHALL suppress a simultaneous start, including the div_zero path.
REQ-029 reset SHALL take priority over flush, and flush SHALL take priority over start.
REQ-030 The strobe outputs (multCtrl, divCtrl), busy and done SHALL be combinational decodes of state and op_q only; div_zero SHALL be registered.
REQ-031 cnt SHALL be $clog2(ITER)+1 bits wide and SHALL never wrap within RUN.
REQ-032 hi and lo SHALL hold their value in every cycle except the DONE capture.

Reset
REQ-033 reset=1 at a rising edge SHALL set state=IDLE, cnt=0, op_q=0, hi=0, lo=0 and div_zero=0.
REQ-034 reset=1 SHALL force multCtrl, divCtrl, busy and done to 0 in the cycle after that edge.
REQ-035 reset=1 mid-operation SHALL abort the operation identically to REQ-033, and the unit result SHALL be discarded.

Verification
REQ-036 Multiply: start, op_div=0, unit model producing 0xFFFFFFFF_FFFFFFFA (3×-2) -> multCtrl high 1 cycle; busy for 34 cycles; done high in cycle 34 after start; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-037 Divide: start, op_div=1, srcB=7, div model rem=2 quot=5 -> divCtrl pulse only; hi=2, lo=5 after done.
REQ-038 Divide-by-zero: start, op_div=1, srcB=0 -> div_zero=1 in the next cycle; busy stays 0; hi/lo unchanged.
REQ-039 Flush: flush at RUN cnt=10 -> IDLE next cycle; no done; hi/lo keep their prior values; a new start then completes normally.
REQ-040 Overlap: start pulsed during RUN and again in the DONE cycle -> both ignored; exactly one done pulse.
REQ-041 Reset mid-RUN: reset at cnt=5 -> all outputs 0 next cycle; hi=lo=0.
